// File: rtl/mem_rd_arbiter.sv
// Two-requester (fetch/load) arbiter for the shared registered memory read port; optional round-robin via MEM_RD_ARBITER_RR_EN.
// Latency: 1 cycle from handshake to rvalid; one grant per cycle.
// Backpressure: ready is combinational from valid/flush only; responses cannot be stalled.
module mem_rd_arbiter #(
    parameter int unsigned SIZE_B = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_valid_i,
    input  logic [31:0] d_addr_i,
    output logic        d_ready_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    input  logic        flush_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    state_t      state;
    logic        gnt_if;
    logic        gnt_d;
    logic        prio_if;
    logic [32:0] last_byte;

`ifdef MEM_RD_ARBITER_RR_EN
    // Remembers which port won the most recent grant; reset value lets fetch win first.
    logic last_gnt_d;

    assign prio_if = last_gnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_d <= 1'b1;
        end else if (gnt_if || gnt_d) begin
            last_gnt_d <= gnt_d;
        end
    end
`else
    assign prio_if = 1'b1;
`endif

    assign gnt_if     = if_valid_i & ~flush_i & (~d_valid_i | prio_if);
    assign gnt_d      = d_valid_i & ~gnt_if;
    assign if_ready_o = gnt_if;
    assign d_ready_o  = gnt_d;
    assign mem_addr_o = gnt_d ? d_addr_i : if_addr_i;

    // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap past the range check.
    assign last_byte = {1'b0, mem_addr_o} + 33'd3;

    // A response still in flight when reset arrives is never presented.
    assign if_rvalid_o = (state == RESP_IF) & ~flush_i & ~rst_i;
    assign d_rvalid_o  = (state == RESP_D) & ~rst_i;
    assign if_rdata_o  = mem_data_i;
    assign d_rdata_o   = mem_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            err_o <= 1'b0;
        end else begin
            if (gnt_if) begin
                state <= RESP_IF;
            end else if (gnt_d) begin
                state <= RESP_D;
            end else begin
                state <= IDLE;
            end
            if ((gnt_if || gnt_d) && (last_byte >= 33'(SIZE_B))) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
